seq_pattern_tx: RTL and testbench
=================================

Name: seq_pattern_tx

Overview:
Serial pattern transmitter that drives the bit-serial stimulus line consumed by the team's Mealy sequence detectors. It accepts a PAT_W-bit pattern, repeat count and inter-frame gap through a valid/ready load handshake. It then shifts the pattern out MSB-first, one bit per clock, and flags the final bit of each frame, which is the cycle where a downstream detector must assert. It sits upstream of the detector on the same serial x line.

Parameters:
PAT_W, 4, pattern length in bits (>=2)
CNT_W, 4, width of repeat-count field
GAP_W, 4, width of inter-frame gap field

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-low (rst==0 at posedge clk resets)
start_valid  input  1  load request
start_ready  output  1  block can accept a load (high only in IDLE)
pat_in  input  PAT_W  pattern, bit PAT_W-1 sent first
rep_in  input  CNT_W  frames to send minus one (0 -> 1 frame)
gap_in  input  GAP_W  idle cycles between frames (0 -> back-to-back)
abort  input  1  terminate transfer
x  output  1  serial data bit (registered)
x_valid  output  1  x carries a pattern bit this cycle
frame_end  output  1  x is the last bit of a frame
busy  output  1  state is SEND or GAP
done  output  1  one-cycle pulse after the final bit of the final frame

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, x=0, x_valid=0, frame_end=0, busy=0, done=0, all counters and latched fields cleared. start_ready=1 from the first cycle after reset. Reset overrides every other input, including during a transfer.
- start_ready = (state==IDLE), decoded from state. A load is accepted at a posedge where start_valid && start_ready. pat_in, rep_in and gap_in are latched at that edge. Inputs are not sampled in any other cycle.
- States:
  - IDLE: waits for a load.
  - SEND: bit counter runs PAT_W-1 down to 0. x=pat[bit], x_valid=1. frame_end=1 when bit==0.
  - GAP: x=0, x_valid=0. Lasts exactly gap cycles.
  - DONE: one cycle with done=1, then IDLE.
- Latency: load accepted at edge T. First bit is on x during cycle T+1. Frame k (0-based) with gap g occupies cycles T+1+k*(PAT_W+g) through T+k*(PAT_W+g)+PAT_W.
- End of frame (SEND, bit==0):
  - Frames remaining and gap>0: go to GAP.
  - Frames remaining and gap==0: reload the bit counter and stay in SEND, so there is no bubble.
  - Last frame: go to DONE.
- GAP exit: at the end of the last gap cycle go to SEND with the bit counter at PAT_W-1.
- Total frames sent = rep_in+1. The repeat counter decrements once per completed frame. rep_in = 2^CNT_W-1 sends 2^CNT_W frames, with no wrap error.
- abort sampled high in SEND or GAP: next state is IDLE, all outputs return to their reset values next cycle, and done is NOT pulsed. abort in IDLE or DONE is ignored, so DONE still pulses.
- start_valid while busy or in DONE: ignored, not queued. A held start_valid is accepted on the first IDLE cycle, which gives a minimum 1-cycle IDLE between transfers.
- When x_valid=0, x must be 0.
- All outputs except start_ready are registered.

Test Plan:
- Default frame: after reset, load pat=4'b1011, rep=0, gap=0 at edge T -> x=1,0,1,1 with x_valid=1 on cycles T+1..T+4. frame_end only at T+4. done=1 only at T+5. start_ready=1 again at T+6.
- Back-to-back repeats: pat=1011, rep=2, gap=0 -> 12 consecutive valid bits 101110111011. frame_end at T+4, T+8, T+12. busy high T+1..T+12. done at T+13. The overlapping-detector model asserts exactly at the frame_end cycles.
- Gapped repeats: pat=1011, rep=1, gap=2 -> valid 1011 on T+1..T+4, x=0/x_valid=0 on T+5..T+6, valid 1011 on T+7..T+10, done at T+11.
- Abort: pat=1011, rep=3, gap=1, assert abort one cycle in the middle of frame 1 -> all outputs return to 0 next cycle, no done, start_ready=1. A new load then sends correctly from bit 3.
- Reset mid-transfer: drive rst=0 for one cycle during GAP -> next cycle matches reset values. An asynchronous-looking rst pulse between edges has no effect.
- Load protection: hold start_valid=1 with a different pat_in throughout a transfer -> the in-flight pattern is unchanged. The second load is accepted only in the first IDLE cycle after done.

Source files
------------

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a latched PAT_W-bit pattern out MSB-first,
// repeating it rep+1 times with an optional idle gap between frames.
module seq_pattern_tx #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [CNT_W-1:0] rep_in,
    input  logic [GAP_W-1:0] gap_in,
    input  logic             abort,
    output logic             x,
    output logic             x_valid,
    output logic             frame_end,
    output logic             busy,
    output logic             done
);

    // Load handshake: a load is taken on any posedge where start_valid && start_ready.
    // start_ready is a pure decode of IDLE; there is no backpressure on the serial side.

    localparam int BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [BIT_W-1:0] BIT_TOP = BIT_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state, state_n;
    logic [BIT_W-1:0] bit_cnt, bit_n;
    logic [CNT_W-1:0] rep_cnt, rep_n;
    logic [GAP_W-1:0] gap_cnt, gap_n;
    logic [GAP_W-1:0] gap_len, gap_len_n;
    logic [PAT_W-1:0] pat, pat_n;
    logic             clear;

    assign start_ready = (state == S_IDLE);

    always_comb begin
        state_n   = state;
        bit_n     = bit_cnt;
        rep_n     = rep_cnt;
        gap_n     = gap_cnt;
        gap_len_n = gap_len;
        pat_n     = pat;
        clear     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_valid) begin
                    state_n   = S_SEND;
                    bit_n     = BIT_TOP;
                    pat_n     = pat_in;
                    rep_n     = rep_in;
                    gap_len_n = gap_in;
                    gap_n     = '0;
                end
            end
            S_SEND: begin
                if (abort) begin
                    state_n = S_IDLE;
                    clear   = 1'b1;
                end else if (bit_cnt == '0) begin
                    if (rep_cnt == '0) begin
                        state_n = S_DONE;
                    end else begin
                        rep_n = rep_cnt - CNT_W'(1);
                        // Counter is preloaded for the next frame whether or not a gap follows.
                        bit_n = BIT_TOP;
                        if (gap_len != '0) begin
                            state_n = S_GAP;
                            gap_n   = gap_len - GAP_W'(1);
                        end
                    end
                end else begin
                    bit_n = bit_cnt - BIT_W'(1);
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_n = S_IDLE;
                    clear   = 1'b1;
                end else if (gap_cnt == '0) begin
                    state_n = S_SEND;
                end else begin
                    gap_n = gap_cnt - GAP_W'(1);
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                clear   = 1'b1;
            end
            default: begin
                state_n = S_IDLE;
                clear   = 1'b1;
            end
        endcase
        if (clear) begin
            bit_n     = '0;
            rep_n     = '0;
            gap_n     = '0;
            gap_len_n = '0;
            pat_n     = '0;
        end
    end

    // Outputs are registered from the next-state values so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            rep_cnt   <= '0;
            gap_cnt   <= '0;
            gap_len   <= '0;
            pat       <= '0;
            x         <= 1'b0;
            x_valid   <= 1'b0;
            frame_end <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_n;
            rep_cnt   <= rep_n;
            gap_cnt   <= gap_n;
            gap_len   <= gap_len_n;
            pat       <= pat_n;
            x         <= (state_n == S_SEND) && pat_n[bit_n];
            x_valid   <= (state_n == S_SEND);
            frame_end <= (state_n == S_SEND) && (bit_n == '0);
            busy      <= (state_n == S_SEND) || (state_n == S_GAP);
            done      <= (state_n == S_DONE);
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed and randomized checks of seq_pattern_tx against a per-cycle expected
// output trace built from the frame/gap/done rules.
module tb_seq_pattern_tx;

    localparam int PAT_W = 4;
    localparam int CNT_W = 4;
    localparam int GAP_W = 4;

    // Expected entry packing: {x, x_valid, frame_end, busy, done, start_ready}
    localparam logic [5:0] IDLE_E = 6'b000001;
    localparam logic [5:0] DONE_E = 6'b000010;
    localparam logic [5:0] GAP_E  = 6'b000100;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start_valid = 1'b0;
    logic             start_ready;
    logic [PAT_W-1:0] pat_in = '0;
    logic [CNT_W-1:0] rep_in = '0;
    logic [GAP_W-1:0] gap_in = '0;
    logic             abort = 1'b0;
    logic             x;
    logic             x_valid;
    logic             frame_end;
    logic             busy;
    logic             done;

    int vectors = 0;
    int miscompares = 0;
    logic [5:0] exp_q[$];

    seq_pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
        .pat_in(pat_in), .rep_in(rep_in), .gap_in(gap_in), .abort(abort),
        .x(x), .x_valid(x_valid), .frame_end(frame_end), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [5:0] observed();
        return {x, x_valid, frame_end, busy, done, start_ready};
    endfunction

    task automatic check(input string tag, input int idx, input logic [5:0] exp_v);
        logic [5:0] obs;
        obs = observed();
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s idx=%0d observed={x,xv,fe,busy,done,rdy}=%b expected=%b",
                   tag, idx, obs, exp_v);
        end
    endtask

    // Reference trace: rep+1 frames MSB-first, gap idle cycles between frames, a done cycle, then idle.
    task automatic build(input logic [PAT_W-1:0] p, input int rep, input int gap);
        for (int k = 0; k <= rep; k++) begin
            for (int b = PAT_W - 1; b >= 0; b--)
                exp_q.push_back({p[b], 1'b1, (b == 0), 1'b1, 1'b0, 1'b0});
            if (k < rep)
                for (int g = 0; g < gap; g++) exp_q.push_back(GAP_E);
        end
        exp_q.push_back(DONE_E);
        exp_q.push_back(IDLE_E);
    endtask

    // cut_kind: 0 none, 1 abort, 2 reset, applied during cycle cut_idx of the trace.
    task automatic run(input string tag, input logic [PAT_W-1:0] p, input int rep, input int gap,
                       input int cut_kind, input int cut_idx, input int glitch_idx,
                       input bit hold, input logic [PAT_W-1:0] p2, input int rep2, input int gap2);
        int drop_idx;
        exp_q.delete();
        build(p, rep, gap);
        if (cut_kind != 0) begin
            while (exp_q.size() > cut_idx + 1) void'(exp_q.pop_back());
            exp_q.push_back(IDLE_E);
            exp_q.push_back(IDLE_E);
        end
        drop_idx = exp_q.size();
        if (hold) build(p2, rep2, gap2);

        vectors++;
        assert (start_ready === 1'b1) else begin
            miscompares++;
            $error("FAIL %s_ready_before_load observed=%b expected=1", tag, start_ready);
        end
        start_valid = 1'b1;
        pat_in = p;
        rep_in = CNT_W'(rep);
        gap_in = GAP_W'(gap);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            check(tag, i, exp_q[i]);
            if (hold) begin
                pat_in = p2;
                rep_in = CNT_W'(rep2);
                gap_in = GAP_W'(gap2);
                start_valid = (i < drop_idx);
            end else begin
                // Junk on the load inputs must not leak into the in-flight transfer.
                start_valid = 1'b0;
                pat_in = PAT_W'($urandom);
                rep_in = CNT_W'($urandom);
                gap_in = GAP_W'($urandom);
            end
            abort = (cut_kind == 1) && (i == cut_idx);
            rst   = !((cut_kind == 2) && (i == cut_idx));
            if (i == glitch_idx) begin
                @(posedge clk);
                #2 rst = 1'b0;
                #2 rst = 1'b1;
            end
        end
        start_valid = 1'b0;
        abort = 1'b0;
        rst = 1'b1;
    endtask

    initial begin
        logic [PAT_W-1:0] rp;
        int rr, rg, busy_len, ck, ci;

        repeat (3) @(negedge clk);
        check("reset_hold", 0, IDLE_E);
        rst = 1'b1;
        @(negedge clk);
        check("reset_release", 0, IDLE_E);

        run("single",   4'b1011, 0, 0, 0, 0, -1, 1'b0, '0, 0, 0);
        run("b2b",      4'b1011, 2, 0, 0, 0, -1, 1'b0, '0, 0, 0);
        run("gapped",   4'b1011, 1, 2, 0, 0, -1, 1'b0, '0, 0, 0);
        run("abort",    4'b1011, 3, 1, 1, 6, -1, 1'b0, '0, 0, 0);
        run("post_abort", 4'b1011, 0, 0, 0, 0, -1, 1'b0, '0, 0, 0);
        run("rst_gap",  4'b1011, 1, 2, 2, 4, -1, 1'b0, '0, 0, 0);
        run("glitch",   4'b1011, 1, 1, 0, 0, 2, 1'b0, '0, 0, 0);
        run("hold",     4'b1011, 0, 1, 0, 0, -1, 1'b1, 4'b0110, 1, 0);
        run("max_rep",  4'b1101, 15, 0, 0, 0, -1, 1'b0, '0, 0, 0);
        run("gap_max",  4'b1001, 1, 15, 0, 0, -1, 1'b0, '0, 0, 0);

        for (int n = 0; n < 24; n++) begin
            rp = PAT_W'($urandom);
            rr = $urandom_range(0, 3);
            rg = $urandom_range(0, 3);
            busy_len = (rr + 1) * PAT_W + rr * rg;
            ck = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            ci = $urandom_range(0, busy_len - 1);
            run("random", rp, rr, rg, ck, ci, -1, 1'b0, '0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
